power_parity_acc: RTL and testbench

POWER_PARITY_ACC -- requirements
Module: power_parity_acc

---
 rtl/power_parity_acc_if.sv | 28 ++
 rtl/power_parity_acc.sv | 91 +++++++++
 tb/tb_power_parity_acc.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/power_parity_acc_if.sv
// Handshake bundle for power_parity_acc: input word stream in, frame parity result out.
// The slave modport is the accumulator; master is the producer/consumer side.
interface power_parity_acc_if #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CW    = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             chk_en;
  logic             chk_bit;
  logic             out_valid;
  logic             out_ready;
  logic             out_parity;
  logic             out_err;
  logic [CW-1:0]    out_count;

  modport slave (
    input  in_valid, in_data, in_last, chk_en, chk_bit, out_ready,
    output in_ready, out_valid, out_parity, out_err, out_count
  );

  modport master (
    output in_valid, in_data, in_last, chk_en, chk_bit, out_ready,
    input  in_ready, out_valid, out_parity, out_err, out_count
  );
endinterface

// File: rtl/power_parity_acc.sv
// Frame parity accumulator: XOR-folds up to FRAME_LEN words per frame, then holds the
// parity, word count and optional check result until the consumer takes it.
module power_parity_acc #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned ODD       = 0,
  parameter int unsigned CW        = $clog2(FRAME_LEN + 1)
) (
  input logic               clk,
  input logic               rst,
  power_parity_acc_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e          r_state;
  logic            r_acc;
  logic [CW-1:0]   r_count;
  logic            r_out_valid;
  logic            r_out_parity;
  logic            r_out_err;
  logic [CW-1:0]   r_out_count;

  logic            w_in_ready;
  logic            w_accept;
  logic            w_acc_next;
  logic [CW-1:0]   w_count_next;
  logic            w_close;
  logic            w_parity_next;

  // Ready is a pure function of state so producers never see a combinational loop.
  assign w_in_ready    = (r_state != StHold);
  assign w_accept      = bus.in_valid && w_in_ready;
  assign w_acc_next    = r_acc ^ (^bus.in_data);
  assign w_count_next  = r_count + CW'(1);
  assign w_close       = bus.in_last || (w_count_next == CW'(FRAME_LEN));
  assign w_parity_next = w_acc_next ^ (ODD != 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_acc        <= 1'b0;
      r_count      <= '0;
      r_out_valid  <= 1'b0;
      r_out_parity <= 1'b0;
      r_out_err    <= 1'b0;
      r_out_count  <= '0;
    end else begin
      unique case (r_state)
        StIdle, StAcc: begin
          if (w_accept) begin
            r_acc   <= w_acc_next;
            r_count <= w_count_next;
            if (w_close) begin
              r_state      <= StHold;
              r_out_valid  <= 1'b1;
              r_out_parity <= w_parity_next;
              r_out_count  <= w_count_next;
              r_out_err    <= bus.chk_en && (w_parity_next != bus.chk_bit);
            end else begin
              r_state <= StAcc;
            end
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_acc       <= 1'b0;
            r_count     <= '0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_parity = r_out_parity;
  assign bus.out_err    = r_out_err;
  assign bus.out_count  = r_out_count;

  a_valid_matches_hold: assert property (@(posedge clk) disable iff (rst)
    r_out_valid == (r_state == StHold));

  a_result_stable: assert property (@(posedge clk) disable iff (rst)
    (r_out_valid && !bus.out_ready) |=>
      (r_out_valid && $stable(r_out_parity) && $stable(r_out_err) && $stable(r_out_count)));

endmodule

// File: tb/tb_power_parity_acc.sv
// Scoreboard bench for power_parity_acc: an even-parity and an odd-parity instance are
// driven with directed frames; monitors pop expected results on every output handshake.
module tb_power_parity_acc;
  localparam int unsigned W   = 3;
  localparam int unsigned FL  = 4;
  localparam int unsigned CWL = $clog2(FL + 1);

  typedef struct packed {
    logic           par;
    logic           err;
    logic [CWL-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  power_parity_acc_if #(.WIDTH(W), .CW(CWL)) bus0 ();
  power_parity_acc_if #(.WIDTH(W), .CW(CWL)) bus1 ();

  power_parity_acc #(.WIDTH(W), .FRAME_LEN(FL), .ODD(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  power_parity_acc #(.WIDTH(W), .FRAME_LEN(FL), .ODD(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  exp_t q0[$];
  exp_t q1[$];
  int   checks  = 0;
  int   errors  = 0;
  int   bubbles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic p, input logic e, input int c);
    exp_t r;
    r.par = p;
    r.err = e;
    r.cnt = CWL'(c);
    return r;
  endfunction

  // Monitors: a negedge with valid&&ready precedes exactly one handshake edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus0.out_valid && bus0.out_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result0: got count %0d expected none", bus0.out_count);
      end else begin
        e = q0.pop_front();
        check("parity0", 32'(bus0.out_parity), 32'(e.par));
        check("err0", 32'(bus0.out_err), 32'(e.err));
        check("count0", 32'(bus0.out_count), 32'(e.cnt));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus1.out_valid && bus1.out_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result1: got count %0d expected none", bus1.out_count);
      end else begin
        e = q1.pop_front();
        check("parity1", 32'(bus1.out_parity), 32'(e.par));
        check("err1", 32'(bus1.out_err), 32'(e.err));
        check("count1", 32'(bus1.out_count), 32'(e.cnt));
      end
    end
  end

  // Presents one word and returns 1 ns after the edge that accepted it.
  task automatic send(input int u, input logic [W-1:0] d, input logic l,
                      input logic ce, input logic cb);
    logic rdy;
    int   n;
    if (u == 0) begin
      bus0.in_valid = 1'b1; bus0.in_data = d; bus0.in_last = l;
      bus0.chk_en = ce; bus0.chk_bit = cb;
    end else begin
      bus1.in_valid = 1'b1; bus1.in_data = d; bus1.in_last = l;
      bus1.chk_en = ce; bus1.chk_bit = cb;
    end
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = (u == 0) ? bus0.in_ready : bus1.in_ready;
      if (!rdy) bubbles++;
      @(posedge clk);
      n++;
    end
    #1;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no in_ready expected in_ready within 50 cycles");
    end
  endtask

  task automatic idle(input int u);
    if (u == 0) begin
      bus0.in_valid = 1'b0; bus0.in_last = 1'b0; bus0.chk_en = 1'b0;
    end else begin
      bus1.in_valid = 1'b0; bus1.in_last = 1'b0; bus1.chk_en = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bus0.in_valid = 0; bus0.in_data = '0; bus0.in_last = 0;
    bus0.chk_en = 0; bus0.chk_bit = 0; bus0.out_ready = 0;
    bus1.in_valid = 0; bus1.in_data = '0; bus1.in_last = 0;
    bus1.chk_en = 0; bus1.chk_bit = 0; bus1.out_ready = 1;

    // Reset acts before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus0.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    check("rst_out_parity", 32'(bus0.out_parity), 32'd0);
    check("rst_out_err", 32'(bus0.out_err), 32'd0);
    check("rst_out_count", 32'(bus0.out_count), 32'd0);
    #10 rst = 1'b0;
    step();

    // Full 4-word frame closes on count.
    bus0.out_ready = 1'b1;
    send(0, 3'b111, 0, 0, 0);
    send(0, 3'b001, 0, 0, 0);
    send(0, 3'b000, 0, 0, 0);
    q0.push_back(mk(0, 0, 4));
    send(0, 3'b110, 0, 0, 0);
    check("full_out_valid", 32'(bus0.out_valid), 32'd1);
    check("full_in_ready", 32'(bus0.in_ready), 32'd0);
    idle(0);
    step();
    check("full_back_idle_ready", 32'(bus0.in_ready), 32'd1);
    check("full_back_idle_valid", 32'(bus0.out_valid), 32'd0);

    // Single-word frames from IDLE, including a check mismatch.
    q0.push_back(mk(0, 0, 1));
    send(0, 3'b101, 1, 0, 0);
    check("single_latency", 32'(bus0.out_valid), 32'd1);
    idle(0);
    step();
    q0.push_back(mk(1, 1, 1));
    send(0, 3'b100, 1, 1, 0);
    idle(0);
    step();

    // Backpressure: result held, a pending word must not be taken.
    bus0.out_ready = 1'b0;
    q0.push_back(mk(1, 0, 2));
    send(0, 3'b010, 0, 0, 0);
    send(0, 3'b011, 1, 1, 1);
    bus0.in_valid = 1'b1; bus0.in_data = 3'b001; bus0.in_last = 1'b1;
    bus0.chk_en = 1'b0; bus0.chk_bit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus0.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus0.in_ready), 32'd0);
      check("hold_parity", 32'(bus0.out_parity), 32'd1);
      check("hold_count", 32'(bus0.out_count), 32'd2);
      check("hold_err", 32'(bus0.out_err), 32'd0);
      step();
    end
    bus0.out_ready = 1'b1;
    q0.push_back(mk(1, 0, 1));
    step();
    check("release_valid", 32'(bus0.out_valid), 32'd0);
    check("release_ready", 32'(bus0.in_ready), 32'd1);
    step();
    check("held_word_frame_valid", 32'(bus0.out_valid), 32'd1);
    idle(0);
    step();

    // Asynchronous reset mid-frame discards the partial frame.
    send(0, 3'b011, 0, 0, 0);
    send(0, 3'b010, 0, 0, 0);
    idle(0);
    #3 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(bus0.out_valid), 32'd0);
    check("midrst_ready", 32'(bus0.in_ready), 32'd1);
    check("midrst_count", 32'(bus0.out_count), 32'd0);
    #2 rst = 1'b0;
    step();
    for (int i = 0; i < 3; i++) send(0, 3'b001, 0, 0, 0);
    q0.push_back(mk(0, 0, 4));
    send(0, 3'b001, 0, 0, 0);
    idle(0);
    step();

    // Reset while a result is held drops it; next frame restarts at count 1.
    bus0.out_ready = 1'b0;
    send(0, 3'b111, 1, 0, 0);
    idle(0);
    #1 rst = 1'b1;
    #1;
    check("holdrst_valid", 32'(bus0.out_valid), 32'd0);
    #1 rst = 1'b0;
    bus0.out_ready = 1'b1;
    step();
    step();
    q0.push_back(mk(0, 0, 1));
    send(0, 3'b000, 1, 0, 0);
    idle(0);
    step();

    // Back-to-back frames with continuous valid; chk on non-closing beats ignored.
    bubbles = 0;
    send(0, 3'b111, 0, 1, 0);
    send(0, 3'b010, 0, 1, 0);
    send(0, 3'b100, 0, 1, 0);
    q0.push_back(mk(1, 0, 4));
    send(0, 3'b011, 0, 0, 0);
    send(0, 3'b101, 0, 1, 0);
    send(0, 3'b110, 0, 1, 0);
    q0.push_back(mk(1, 0, 3));
    send(0, 3'b001, 1, 1, 1);
    idle(0);
    check("b2b_bubbles", 32'(bubbles), 32'd1);
    step();

    // Odd-parity instance.
    q1.push_back(mk(0, 0, 2));
    send(1, 3'b011, 0, 0, 0);
    send(1, 3'b010, 1, 1, 0);
    idle(1);
    q1.push_back(mk(1, 1, 1));
    send(1, 3'b000, 1, 1, 0);
    idle(1);

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d results pending expected 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
